paralelo_serial: RTL

//  Transmit-side serializer for the PCIe-style physical-layer lane. It is the counterpart of the serial_paralelo receiver.

---
 rtl/paralelo_serial_pkg.sv | 19 +
 rtl/paralelo_serial_if.sv | 38 +++
 rtl/paralelo_serial_piso_shift.sv | 44 ++++
 rtl/paralelo_serial.sv | 89 ++++++++
 4 files changed

// File: rtl/paralelo_serial_pkg.sv
// ---------------------------------------------------------------------------
// paralelo_serial_pkg
//   Definitions shared by the PCIe-style physical-layer lane serializer
//   (paralelo_serial) and its receiver counterpart (serial_paralelo):
//   symbol width, the COM alignment/idle symbol and the link-state encoding.
// ---------------------------------------------------------------------------
package paralelo_serial_pkg;

  localparam int SYM_W = 8;

  // K28.5-style comma used both as training preamble and as line idle fill.
  localparam logic [SYM_W-1:0] COM_SYM = 8'hBC;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/paralelo_serial_if.sv
// ---------------------------------------------------------------------------
// paralelo_serial_if
//   Bundles the symbol-side handshake and the serial line of the lane
//   serializer.
//   data_in  : parallel symbol offered by upstream
//   valid    : data_in qualifier
//   data_out : serial line, MSB first
//   ready    : one-cycle pulse, the next edge samples data_in/valid
//   active   : sync preamble finished
//   master = upstream/line observer, slave = serializer.
// ---------------------------------------------------------------------------
interface paralelo_serial_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] data_in;
  logic             valid;
  logic             data_out;
  logic             ready;
  logic             active;

  modport master (
    output data_in,
    output valid,
    input  data_out,
    input  ready,
    input  active
  );

  modport slave (
    input  data_in,
    input  valid,
    output data_out,
    output ready,
    output active
  );

endinterface

// File: rtl/paralelo_serial_piso_shift.sv
// ---------------------------------------------------------------------------
// piso_shift
//   WIDTH-bit parallel-in/serial-out shift register, MSB first.
//   clk     : bit clock
//   rst_n   : asynchronous active-low reset, clears the register
//   load_i  : capture d_i (has priority over shift_i)
//   shift_i : shift left by one, zero fill
//   d_i     : parallel word
//   msb_o   : current MSB of the register (a flop output)
// ---------------------------------------------------------------------------
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = d_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/paralelo_serial.sv
// ---------------------------------------------------------------------------
// paralelo_serial
//   Transmit-side lane serializer. Sends SYNC_SYMBOLS COM symbols after
//   reset so the receiver can lock alignment, then serializes one symbol
//   every WIDTH clk_32f cycles, MSB first, with no gaps. When valid is low
//   at a load edge the line is filled with COM.
//   clk_32f : bit clock, rising edge
//   reset   : asynchronous active-low reset
//   bus     : slave side of paralelo_serial_if
//             (data_in, valid in; data_out, ready, active out)
// ---------------------------------------------------------------------------
module paralelo_serial
  import paralelo_serial_pkg::*;
#(
  parameter int               WIDTH        = SYM_W,
  parameter logic [WIDTH-1:0] COM          = WIDTH'(COM_SYM),
  parameter int               SYNC_SYMBOLS = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  paralelo_serial_if.slave  bus
);

  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SCW = $clog2(SYNC_SYMBOLS + 1);

  state_e           state_q, state_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SCW-1:0]   sync_cnt_q, sync_cnt_d;
  logic             load;
  logic [WIDTH-1:0] sym;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q    <= SYNC;
      bit_cnt_q  <= '0;
      sync_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    sym        = COM;
    load       = (bit_cnt_q == '0);
    bit_cnt_d  = (bit_cnt_q == BCW'(WIDTH - 1)) ? '0 : bit_cnt_q + BCW'(1);

    case (state_q)
      SYNC: begin
        if (load) begin
          if (sync_cnt_q != SCW'(SYNC_SYMBOLS)) begin
            sync_cnt_d = sync_cnt_q + SCW'(1);
          end
          // This edge loads the last preamble COM; data is taken from the next symbol slot.
          if (sync_cnt_q == SCW'(SYNC_SYMBOLS - 1)) begin
            state_d = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        sym = bus.valid ? bus.data_in : COM;
      end
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  assign bus.ready  = (state_q == ACTIVE) && load;
  assign bus.active = (state_q == ACTIVE);

  // The shifter MSB flop is the line driver: a load puts S[MSB] on the line,
  // each following shift exposes the next lower bit.
  piso_shift #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk     (clk_32f),
    .rst_n   (reset),
    .load_i  (load),
    .shift_i (!load),
    .d_i     (sym),
    .msb_o   (bus.data_out)
  );

endmodule
